// File: rtl/riscv_path_mailbox_if.sv
// CPU store/readback bus plus the path-node stream and status flags of the path mailbox.
// master = CPU/consumer side, slave = mailbox side.
interface riscv_path_mailbox_if #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned NODE_W = 8
);
   localparam int unsigned IDX_W = $clog2(DEPTH) + 1;

   logic              MemWrite;
   logic [31:0]       DataAdr;
   logic [31:0]       WriteData;
   logic [31:0]       ReadData;
   logic              node_valid;
   logic              node_ready;
   logic [NODE_W-1:0] node_data;
   logic              node_last;
   logic [IDX_W-1:0]  index;
   logic              cpu_done;
   logic              overflow;

   modport master (
      output MemWrite, DataAdr, WriteData, node_ready,
      input  ReadData, node_valid, node_data, node_last, index, cpu_done, overflow
   );

   modport slave (
      input  MemWrite, DataAdr, WriteData, node_ready,
      output ReadData, node_valid, node_data, node_last, index, cpu_done, overflow
   );
endinterface

// File: rtl/riscv_path_mailbox.sv
// Path mailbox: CPU pushes nodes then commits; nodes drain in order on a valid/ready stream.
// Stores take effect on the next edge; node_data holds while node_ready is low; ReadData is combinational.
module riscv_path_mailbox #(
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned NODE_W   = 8,
   parameter logic [31:0] BASE_ADR = 32'h0200_0000
) (
   input  logic               adc_sck,
   input  logic               reset,
   input  logic               cpu_reset,
   riscv_path_mailbox_if.slave bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned IDX_W = PTR_W + 1;

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_DRAIN   = 2'd1,
      ST_FINISH  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  index_q, index_d;
   logic [IDX_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic              cpu_done_q, cpu_done_d;
   logic              overflow_q, overflow_d;
   logic [NODE_W-1:0] slot_q [DEPTH];

   logic push_we;
   logic done_we;
   logic clear_we;
   logic stat_sel;
   logic full;
   logic node_vld;
   logic at_last;
   logic xfer;
   logic slot_we;

   assign push_we  = bus.MemWrite && (bus.DataAdr == BASE_ADR);
   assign done_we  = bus.MemWrite && (bus.DataAdr == BASE_ADR + 32'd4);
   assign clear_we = bus.MemWrite && (bus.DataAdr == BASE_ADR + 32'd8);
   assign stat_sel = (bus.DataAdr == BASE_ADR + 32'd12);

   assign full     = (index_q == IDX_W'(DEPTH));
   assign node_vld = (state_q == ST_DRAIN);
   assign at_last  = (rd_ptr_q == index_q - IDX_W'(1));
   assign xfer     = node_vld && bus.node_ready;

   // cpu_reset wins over a same-cycle push, so the slot is not written either.
   assign slot_we  = push_we && (state_q == ST_COLLECT) && !full && !cpu_reset;

   assign bus.node_valid = node_vld;
   assign bus.node_last  = node_vld && at_last;
   assign bus.node_data  = slot_q[rd_ptr_q[PTR_W-1:0]];
   assign bus.index      = index_q;
   assign bus.cpu_done   = cpu_done_q;
   assign bus.overflow   = overflow_q;
   assign bus.ReadData   = stat_sel ? {overflow_q, cpu_done_q, state_q, 12'b0, 16'(index_q)} : 32'b0;

   always_comb begin
      state_d    = state_q;
      index_d    = index_q;
      rd_ptr_d   = rd_ptr_q;
      cpu_done_d = cpu_done_q;
      overflow_d = overflow_q;

      if (cpu_reset || clear_we) begin
         state_d    = ST_COLLECT;
         index_d    = '0;
         rd_ptr_d   = '0;
         cpu_done_d = 1'b0;
         overflow_d = 1'b0;
      end else begin
         case (state_q)
            ST_COLLECT: begin
               if (push_we) begin
                  if (full) begin
                     overflow_d = 1'b1;
                  end else begin
                     index_d = index_q + IDX_W'(1);
                  end
               end else if (done_we) begin
                  cpu_done_d = 1'b1;
                  rd_ptr_d   = '0;
                  state_d    = (index_q != '0) ? ST_DRAIN : ST_FINISH;
               end
            end
            ST_DRAIN: begin
               if (push_we || done_we) begin
                  overflow_d = 1'b1;
               end
               if (xfer) begin
                  rd_ptr_d = rd_ptr_q + IDX_W'(1);
                  if (at_last) begin
                     state_d = ST_FINISH;
                  end
               end
            end
            default: begin
               if (push_we || done_we) begin
                  overflow_d = 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge adc_sck or posedge reset) begin
      if (reset) begin
         state_q    <= ST_COLLECT;
         index_q    <= '0;
         rd_ptr_q   <= '0;
         cpu_done_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         index_q    <= index_d;
         rd_ptr_q   <= rd_ptr_d;
         cpu_done_q <= cpu_done_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage survives CLEAR/cpu_reset; only the hard reset zeroes it.
   always_ff @(posedge adc_sck or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            slot_q[i] <= '0;
         end
      end else if (slot_we) begin
         slot_q[index_q[PTR_W-1:0]] <= bus.WriteData[NODE_W-1:0];
      end
   end

   if (NODE_W < 32) begin : g_wd_unused
      logic unused_wd;
      assign unused_wd = ^bus.WriteData[31:NODE_W];
   end
endmodule
